mdu_seq: RTL and testbench

- Multi-cycle multiply/divide responder on the execute-stage start/busy/result interface.
- The execute stage presents operands and MDOp with a one-cycle start pulse. This block latches them and asserts busy for the operation latency, then commits to the HI/LO registers.
- It serves MFHI/MFLO reads combinationally through result. MTHI/MTLO are single-cycle writes.
- Pipeline stall logic consumes busy.

---
 rtl/mdu_seq_pkg.sv | 14 +
 rtl/mdu_seq_arith.sv | 30 +++
 rtl/mdu_seq.sv | 52 +++++
 tb/tb_mdu_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: MDOp encodings and default latencies shared by the execute stage and the MDU.
package mdu_seq_pkg;
  typedef logic [2:0] md_op_t;
  localparam md_op_t MD_MULT  = 3'b000;
  localparam md_op_t MD_MULTU = 3'b001;
  localparam md_op_t MD_DIV   = 3'b010;
  localparam md_op_t MD_DIVU  = 3'b011;
  localparam md_op_t MD_MFHI  = 3'b100;
  localparam md_op_t MD_MFLO  = 3'b101;
  localparam md_op_t MD_MTHI  = 3'b110;
  localparam md_op_t MD_MTLO  = 3'b111;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu_seq_arith.sv
// md_arith: combinational {hi,lo} for MULT/MULTU/DIV/DIVU plus a divide-by-zero flag.
module md_arith
  import mdu_seq_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);
  logic        sgn, dz;
  logic [31:0] ma, mb, d, q, r, qs, rs;
  logic [63:0] smul, umul;
  always_comb begin
    smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    umul = {32'b0, a} * {32'b0, b};
    sgn = ~op[0];
    // divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    ma = (sgn & a[31]) ? -a : a;
    mb = (sgn & b[31]) ? -b : b;
    dz = b == 32'd0;
    d = dz ? 32'd1 : mb;
    q = ma / d;
    r = ma % d;
    qs = (sgn & (a[31] ^ b[31])) ? -q : q;
    rs = (sgn & a[31]) ? -r : r;
    res = op[1] ? {rs, qs} : op[0] ? umul : smul;
    div_zero = op[1] & dz;
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO registers and a busy window for stall logic.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic [31:0] result
);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  logic        state, skip, dz;
  logic [15:0] cnt;
  logic [31:0] hi, lo;
  logic [63:0] pend, ar;
  md_arith u_arith (.op(MDOp), .a(D1), .b(D2), .res(ar), .div_zero(dz));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend <= '0;
      skip <= 1'b0;
    end else if (state == IDLE) begin
      if (start & ~MDOp[2]) begin
        pend <= ar;
        skip <= dz;
        cnt <= MDOp[1] ? 16'(DIV_CYCLES - 1) : 16'(MULT_CYCLES - 1);
        state <= RUN;
      end else if (start & (MDOp == MD_MTHI)) begin
        hi <= D1;
      end else if (start & (MDOp == MD_MTLO)) begin
        lo <= D1;
      end
    end else if (cnt == 16'd0) begin
      state <= IDLE;
      if (!skip) {hi, lo} <= pend;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end
  assign busy = state == RUN;
  assign result = (MDOp == MD_MFHI) ? hi : lo;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random stimulus against a behavioural HI/LO model of mdu_seq.
module tb_mdu_seq;
  import mdu_seq_pkg::*;
  localparam int ML = 5;
  localparam int DL = 10;
  logic clk = 0, reset = 0, start = 0, busy;
  logic [2:0] MDOp = 0;
  logic [31:0] D1 = 0, D2 = 0, result;
  int vecs = 0, errs = 0, left = 0, nb;
  logic [31:0] mhi = 0, mlo = 0;
  logic [63:0] pv = 0;
  logic pz = 0, armed = 0;

  mdu_seq #(.MULT_CYCLES(ML), .DIV_CYCLES(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .MDOp(MDOp),
    .D1(D1), .D2(D2), .busy(busy), .result(result)
  );

  always #5 clk = ~clk;

  // reference arithmetic straight from the ISA rules: {div_by_zero, hi, lo}
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] u;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      MD_MULT: begin p = longint'(sa) * longint'(sb); return {1'b0, p}; end
      MD_MULTU: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
      MD_DIV: begin
        if (b == 0) return {1'b1, 64'd0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    logic [64:0] rr;
    if (!reset) begin
      mhi = 0; mlo = 0; left = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0 && !pz) begin mhi = pv[63:32]; mlo = pv[31:0]; end
    end else if (start) begin
      if (!MDOp[2]) begin
        left = MDOp[1] ? DL : ML;
        rr = ref_op(MDOp, D1, D2);
        pz = rr[64];
        pv = rr[63:0];
      end else if (MDOp == MD_MTHI) mhi = D1;
      else if (MDOp == MD_MTLO) mlo = D1;
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      vecs++;
      if (busy !== (left > 0)) begin
        errs++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy, left > 0);
      end
      vecs++;
      if (result !== ((MDOp == MD_MFHI) ? mhi : mlo)) begin
        errs++;
        $display("FAIL result t=%0t op=%0d got=%h want=%h", $time, MDOp, result, (MDOp == MD_MFHI) ? mhi : mlo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = s; MDOp = op; D1 = a; D2 = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
      step(0, MD_MFHI, 0, 0);
    end
    errs++;
    $display("FAIL timeout busy never fell got=%0d want<40", n);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    step(1, op, a, b);
    step(0, MD_MFHI, 0, 0);
    wait_idle(n);
  endtask

  task automatic rd(input string name, input logic [2:0] op, input logic [31:0] exp);
    step(0, op, 0, 0);
    @(negedge clk);
    chk(name, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(0, MD_MFHI, 0, 0);
    step(0, MD_MFHI, 0, 0);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_hi", result, 0);
    step(0, MD_MFHI, 0, 0);
    reset = 1;
    run_op(MD_MULT, 32'hFFFFFFFE, 3, nb);
    chk("mult_busy_len", nb, 5);
    rd("mult_hi", MD_MFHI, 32'hFFFFFFFF);
    rd("mult_lo", MD_MFLO, 32'hFFFFFFFA);
    run_op(MD_MULTU, 32'hFFFFFFFE, 3, nb);
    rd("multu_hi", MD_MFHI, 32'h00000002);
    rd("multu_lo", MD_MFLO, 32'hFFFFFFFA);
    run_op(MD_DIV, 32'hFFFFFFF9, 2, nb);
    chk("div_busy_len", nb, 10);
    rd("div_lo", MD_MFLO, 32'hFFFFFFFD);
    rd("div_hi", MD_MFHI, 32'hFFFFFFFF);
    run_op(MD_DIVU, 7, 2, nb);
    rd("divu_lo", MD_MFLO, 3);
    rd("divu_hi", MD_MFHI, 1);
    step(1, MD_MTHI, 32'h11, 0);
    step(1, MD_MTLO, 32'h22, 0);
    run_op(MD_DIV, 32'd55, 0, nb);
    chk("div0_busy_len", nb, 10);
    rd("div0_hi", MD_MFHI, 32'h11);
    rd("div0_lo", MD_MFLO, 32'h22);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
    rd("ovf_lo", MD_MFLO, 32'h80000000);
    rd("ovf_hi", MD_MFHI, 0);
    step(1, MD_MTHI, 32'hDEADBEEF, 0);
    rd("mthi", MD_MFHI, 32'hDEADBEEF);
    chk("mthi_busy", 32'(busy), 0);
    step(1, MD_MTLO, 32'h1234, 0);
    rd("mtlo", MD_MFLO, 32'h1234);
    step(1, MD_MULT, 3, 4);
    step(0, MD_MFHI, 0, 0);
    step(1, MD_DIV, 9, 3);
    step(0, MD_MFHI, 0, 0);
    wait_idle(nb);
    chk("midstart_busy_tail", nb, 3);
    rd("midstart_lo", MD_MFLO, 12);
    rd("midstart_hi", MD_MFHI, 0);
    step(1, MD_DIV, 100, 7);
    repeat (4) step(0, MD_MFHI, 0, 0);
    reset = 0;
    step(0, MD_MFHI, 0, 0);
    reset = 1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_hi", result, 0);
    repeat (12) step(0, MD_MFLO, 0, 0);
    @(negedge clk);
    chk("rstmid_lo_late", result, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick());
      reset = $urandom_range(0, 299) != 0;
    end
    step(0, MD_MFHI, 0, 0);
    reset = 1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
